// File: rtl/tl_pkg.sv
// Shared types and constants for the two-road traffic light sequencer.
// Phase encodings are fixed: the phase value is exported on the s output
// and consumed directly by the light drivers.
package tl_pkg;

  // Intersection phases; 6/7 only become reachable with TRAFFIC_PED_EN.
  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_A  = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_B  = 3'd5,
    WALK_TO_B = 3'd6,
    WALK_TO_A = 3'd7
  } phase_t;

  // Light codes shared by both roads.
  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

  // Default dwell times, in ticks.
  localparam int GREEN_MIN_DEF = 5;
  localparam int GREEN_MAX_DEF = 10;
  localparam int YELLOW_T_DEF  = 3;
  localparam int ALLRED_T_DEF  = 1;
  localparam int WALK_T_DEF    = 4;

  // True for either pedestrian walk phase.
  function automatic logic is_walk(input phase_t p);
    return (p == WALK_TO_B) || (p == WALK_TO_A);
  endfunction

endpackage

// File: rtl/tl_state_reg.sv
// Phase register for the traffic sequencer. Resets synchronously
// (active-low) to ALLRED_B so the first green after reset goes to road A.
module tl_state_reg
  import tl_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  phase_t i_next,
  output phase_t o_phase
);

  phase_t r_phase;

  // Hold the current phase; reset forces the clearance phase after B.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_phase <= ALLRED_B;
    end else begin
      r_phase <= i_next;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/traffic_ctrl.sv
// Two-road intersection sequencer. Computes the next phase from the road
// sensors and a per-phase dwell timer, and decodes the phase into light
// codes for road A and road B.
// Optional feature macro: TRAFFIC_PED_EN adds the pedestrian request
// input, the walk lamp output and the two walk phases.
module traffic_ctrl
  import tl_pkg::*;
#(
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int GREEN_MAX = GREEN_MAX_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int ALLRED_T  = ALLRED_T_DEF,
  parameter int WALK_T    = WALK_T_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ta,
  input  logic       tb,
`ifdef TRAFFIC_PED_EN
  input  logic       ped_req,
`endif
  output logic [2:0] s,
  output logic [1:0] la,
  output logic [1:0] lb
`ifdef TRAFFIC_PED_EN
  ,
  output logic       walk
`endif
);

  // Timer must count up to the longest dwell it is compared against.
  localparam int DWELL_MAX = (GREEN_MAX > WALK_T) ? GREEN_MAX : WALK_T;
  localparam int TW        = $clog2(DWELL_MAX + 1);

  localparam logic [TW-1:0] T_SAT    = {TW{1'b1}};
  localparam logic [TW-1:0] T_GMIN   = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] T_GMAX   = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T - 1);
`ifdef TRAFFIC_PED_EN
  localparam logic [TW-1:0] T_WALK   = TW'(WALK_T - 1);
`endif

  phase_t        w_phase;
  phase_t        w_next;
  logic [TW-1:0] r_timer;
  logic          w_demand_a;
  logic          w_demand_b;
  logic          w_ped_pend;

`ifdef TRAFFIC_PED_EN
  logic          r_ped_pend;
  logic          w_enter_walk;

  assign w_ped_pend   = r_ped_pend;
  assign w_enter_walk = is_walk(w_next) && !is_walk(w_phase);
`else
  assign w_ped_pend   = 1'b0;
`endif

  // Cross-road demand: a waiting vehicle, or a pending pedestrian request.
  assign w_demand_a = ta | w_ped_pend;
  assign w_demand_b = tb | w_ped_pend;

  tl_state_reg u_state (
    .clk     (clk),
    .reset   (reset),
    .i_next  (w_next),
    .o_phase (w_phase)
  );

  // Next-phase selection; normal transitions only happen in tick cycles.
  always_comb begin
    w_next = w_phase;
    case (w_phase)
      A_GREEN: begin
        if (tick && (r_timer >= T_GMIN) && w_demand_b &&
            (!ta || (r_timer >= T_GMAX))) begin
          w_next = A_YELLOW;
        end else begin
          w_next = A_GREEN;
        end
      end
      A_YELLOW: begin
        if (tick && (r_timer == T_YELLOW)) begin
          w_next = ALLRED_A;
        end else begin
          w_next = A_YELLOW;
        end
      end
      ALLRED_A: begin
        if (tick && (r_timer == T_ALLRED)) begin
`ifdef TRAFFIC_PED_EN
          w_next = w_ped_pend ? WALK_TO_B : B_GREEN;
`else
          w_next = B_GREEN;
`endif
        end else begin
          w_next = ALLRED_A;
        end
      end
      B_GREEN: begin
        if (tick && (r_timer >= T_GMIN) && w_demand_a &&
            (!tb || (r_timer >= T_GMAX))) begin
          w_next = B_YELLOW;
        end else begin
          w_next = B_GREEN;
        end
      end
      B_YELLOW: begin
        if (tick && (r_timer == T_YELLOW)) begin
          w_next = ALLRED_B;
        end else begin
          w_next = B_YELLOW;
        end
      end
      ALLRED_B: begin
        if (tick && (r_timer == T_ALLRED)) begin
`ifdef TRAFFIC_PED_EN
          w_next = w_ped_pend ? WALK_TO_A : A_GREEN;
`else
          w_next = A_GREEN;
`endif
        end else begin
          w_next = ALLRED_B;
        end
      end
`ifdef TRAFFIC_PED_EN
      WALK_TO_B: begin
        if (tick && (r_timer == T_WALK)) begin
          w_next = B_GREEN;
        end else begin
          w_next = WALK_TO_B;
        end
      end
      WALK_TO_A: begin
        if (tick && (r_timer == T_WALK)) begin
          w_next = A_GREEN;
        end else begin
          w_next = WALK_TO_A;
        end
      end
`endif
      // Walk phases without the pedestrian feature are illegal: recover
      // immediately, independent of tick.
      default: begin
        w_next = ALLRED_B;
      end
    endcase
  end

  // Dwell timer: cleared on every phase change, else counts ticks and saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_timer <= {TW{1'b0}};
    end else if (w_next != w_phase) begin
      r_timer <= {TW{1'b0}};
    end else if (tick && (r_timer != T_SAT)) begin
      r_timer <= r_timer + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      r_timer <= r_timer;
    end
  end

`ifdef TRAFFIC_PED_EN
  // Pedestrian request latch: cleared when a walk phase starts, requests
  // arriving during a walk phase are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ped_pend <= 1'b0;
    end else if (w_enter_walk) begin
      r_ped_pend <= 1'b0;
    end else if (ped_req && !is_walk(w_phase)) begin
      r_ped_pend <= 1'b1;
    end else begin
      r_ped_pend <= r_ped_pend;
    end
  end

  assign walk = is_walk(w_phase);
`endif

  assign s = w_phase;

  // Moore decode of the current phase into road light codes.
  always_comb begin
    la = LIGHT_RED;
    lb = LIGHT_RED;
    case (w_phase)
      A_GREEN:  la = LIGHT_GREEN;
      A_YELLOW: la = LIGHT_YELLOW;
      B_GREEN:  lb = LIGHT_GREEN;
      B_YELLOW: lb = LIGHT_YELLOW;
      default: begin
        la = LIGHT_RED;
        lb = LIGHT_RED;
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench for traffic_ctrl with GREEN_MIN=3, GREEN_MAX=6,
// YELLOW_T=2, ALLRED_T=1, WALK_T=4. The stimulus process pushes the
// hand-computed phase expected after each clock edge; the monitor pops
// and compares on the following falling edge.
module tb_traffic_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       ta;
  logic       tb;
  logic [2:0] s;
  logic [1:0] la;
  logic [1:0] lb;
`ifdef TRAFFIC_PED_EN
  logic       ped_req;
  logic       walk;
`endif

  typedef struct {
    logic [2:0] s;
    logic       walk;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  traffic_ctrl #(
    .GREEN_MIN (3),
    .GREEN_MAX (6),
    .YELLOW_T  (2),
    .ALLRED_T  (1),
    .WALK_T    (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .ta      (ta),
    .tb      (tb),
`ifdef TRAFFIC_PED_EN
    .ped_req (ped_req),
`endif
    .s       (s),
    .la      (la),
    .lb      (lb)
`ifdef TRAFFIC_PED_EN
    ,
    .walk    (walk)
`endif
  );

  function automatic logic [1:0] exp_la(input logic [2:0] p);
    if (p == 3'd0) return 2'b00;
    else if (p == 3'd1) return 2'b01;
    else return 2'b10;
  endfunction

  function automatic logic [1:0] exp_lb(input logic [2:0] p);
    if (p == 3'd3) return 2'b00;
    else if (p == 3'd4) return 2'b01;
    else return 2'b10;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation once per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check({e.tag, ".s"}, int'(s), int'(e.s));
      check({e.tag, ".la"}, int'(la), int'(exp_la(e.s)));
      check({e.tag, ".lb"}, int'(lb), int'(exp_lb(e.s)));
`ifdef TRAFFIC_PED_EN
      check({e.tag, ".walk"}, int'(walk), int'(e.walk));
`endif
    end
  end

  // Drive one clock cycle and queue the phase expected after its edge.
  task automatic cyc(input logic r, input logic t, input logic a, input logic b,
                     input logic [2:0] es, input string tag);
    exp_t e;
    reset = r;
    tick  = t;
    ta    = a;
    tb    = b;
    @(posedge clk);
    #1;
    e.s    = es;
    e.walk = (es == 3'd6) || (es == 3'd7);
    e.tag  = tag;
    q.push_back(e);
  endtask

`ifdef TRAFFIC_PED_EN
  task automatic set_ped(input logic p);
    ped_req = p;
  endtask
`endif

  logic [2:0] seq3 [6]  = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
  logic [2:0] seq4 [18] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0,
                            3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3};
  logic [2:0] hold5 [5] = '{3'd5, 3'd0, 3'd0, 3'd0, 3'd1};
  logic [2:0] next5 [5] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1};
`ifdef TRAFFIC_PED_EN
  logic [2:0] seq6 [13] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2,
                            3'd6, 3'd6, 3'd6, 3'd6, 3'd3};
`endif

  initial begin
    reset = 1'b0;
    tick  = 1'b1;
    ta    = 1'b0;
    tb    = 1'b0;
`ifdef TRAFFIC_PED_EN
    ped_req = 1'b0;
`endif

    // Reset held for two clocks, then released: first tick goes to A_GREEN.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, "reset_hold");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, "reset_overrides");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "reset_release");

    // No demand on either road: A green is held indefinitely.
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, "idle_hold");

    // Re-enter A_GREEN fresh with only road B waiting: 3/2/1 ticks.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, "reset_again");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, "a_entry");
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, seq3[i], "b_demand");

    // Both roads saturated: each green lasts GREEN_MAX, period 18 ticks.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 18; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, seq4[i], "saturated");

    // Tick every fifth clock, sensors glitch between ticks.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, "slow_reset");
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, hold5[p], "slow_hold");
      cyc(1'b1, 1'b1, 1'b0, 1'b1, next5[p], "slow_tick");
    end
    // Now in A_YELLOW mid-dwell: reset beats a simultaneous tick.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd5, "reset_midphase");
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, "post_reset_hold");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, "timer_cleared");

`ifdef TRAFFIC_PED_EN
    // Pedestrian request while A holds green with ta=1, tb=0.
    for (int i = 0; i < 13; i++) begin
      if (i == 3) set_ped(1'b1);
      else set_ped(1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, seq6[i], "ped_walk");
    end
    set_ped(1'b0);
`endif

    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
